sync_ram: RTL
=============

SYNC_RAM -- requirements
Module: sync_ram

Interface
REQ-001 The block SHALL have parameter RAM_DATASIZE, default 8, data word width in bits.
REQ-002 The block SHALL have parameter RAM_ADRSIZE, default 5, address width in bits.
REQ-003 The block SHALL have parameter RAMDEPTH, default 1 << RAM_ADRSIZE, number of words.
REQ-004 The block SHALL have parameter RAM_RDLAT, default 1, legal range 1..4, read latency in clock edges.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset; all state changes SHALL occur on the CLK rising edge except reset.
REQ-006 The block SHALL have port CLK, input, 1 bit, clock.
REQ-007 The block SHALL have port RST_N, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port CS_N, input, 1 bit, active-low chip select.
REQ-009 The block SHALL have port WE, input, 1 bit, 1 = write, 0 = read, qualified by CS_N.
REQ-010 The block SHALL have port ADR, input, RAM_ADRSIZE bits, word address.
REQ-011 The block SHALL have port DIN, input, RAM_DATASIZE bits, write data.
REQ-012 The block SHALL have port CLR, input, 1 bit, single-cycle request to zero the whole array.
REQ-013 The block SHALL have port DOUT, output, RAM_DATASIZE bits, registered read data.
REQ-014 The block SHALL have port DVALID, output, 1 bit, one-cycle pulse marking new DOUT.
REQ-015 The block SHALL have port RDY, output, 1 bit, 1 = array initialised and accepting accesses.

Function
REQ-016 The block SHALL implement a two-state FSM: ST_CLEAR (zeroing array) and ST_READY (normal access).
REQ-017 In ST_CLEAR, a clear counter SHALL write zero to address 0, 1, ... RAMDEPTH-1, one word per edge, then enter ST_READY on the following edge.
REQ-018 RDY SHALL be 1 exactly when state is ST_READY.
REQ-019 An access SHALL be accepted at an edge when RDY=1, CS_N=0 and CLR=0; otherwise CS_N, WE, ADR, DIN SHALL be ignored.
REQ-020 An accepted write SHALL store DIN at MEM[ADR] on that edge; DOUT and DVALID SHALL not change due to a write.
REQ-021 An accepted read SHALL sample MEM[ADR] on that edge (edge N); DOUT SHALL take that value and DVALID SHALL be 1 after edge N+RAM_RDLAT-1, and DVALID SHALL be 0 after the next edge unless another read completes.
REQ-022 Back-to-back reads SHALL be accepted every edge; reads SHALL complete in issue order, one per edge.
REQ-023 A read followed by a write to the same address on the next edge SHALL return the old data.
REQ-024 DOUT SHALL hold its last value when no read completes.
REQ-025 CLR=1 in ST_READY SHALL enter ST_CLEAR on that edge, restart the clear counter at 0, and drop any access presented in the same cycle.
REQ-026 CLR=1 while in ST_CLEAR SHALL be ignored (no counter restart).
REQ-027 Reads in flight when CLR is taken SHALL still complete with their pre-clear data at their scheduled edge.
REQ-028 Address values at or above RAMDEPTH SHALL be ignored for writes and return zero for reads.

Reset
REQ-029 On RST_N=0 the block SHALL immediately set state to ST_CLEAR, clear counter to 0, DOUT to 0, DVALID to 0, RDY to 0, and flush the read pipeline.
REQ-030 Reset asserted mid-clear or mid-read SHALL abort the operation; after RST_N rises a full clear SHALL run (RAMDEPTH edges) before RDY=1.
REQ-031 Array contents SHALL NOT be reset asynchronously; zeroing SHALL happen only through ST_CLEAR.

Structure
REQ-032 A shared package ram_pkg SHALL hold the state typedef (ST_CLEAR, ST_READY) and default width/depth/latency constants.
REQ-033 The read-latency delay line (data plus valid, RAM_RDLAT-1 stages) SHALL be the sub-module ram_rdpipe.

Verification
REQ-034 Reset release, defaults -> RDY=0 for 32 edges, RDY=1 after the 33rd edge; DOUT=0, DVALID=0 throughout.
REQ-035 Write 8'hA5 to ADR 3, read ADR 3 with RAM_RDLAT=1 and =3 -> DOUT=8'hA5 with one DVALID pulse after edge N and N+2 respectively.
REQ-036 Reads of ADR 0..7 on consecutive edges after writing 8'h10..8'h17 -> eight consecutive DVALID pulses, DOUT 8'h10..8'h17 in order.
REQ-037 Write 8'hFF to ADR 31, assert CLR with a simultaneous write of 8'h55 to ADR 0 -> RDY=0 for 32 edges, then reads of ADR 0 and 31 return 8'h00.
REQ-038 Assert RST_N=0 at clear count 10, release -> RDY rises only after a full 32-edge clear; accesses during clear produce no DVALID.
REQ-039 Read ADR 5 (holding 8'h3C) with RAM_RDLAT=3, assert CLR next edge -> DVALID pulse with DOUT=8'h3C at the scheduled edge while RDY=0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and default geometry for the synchronous RAM.
// Imported by the RAM top and its read-latency pipeline.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

  localparam int RAM_DATASIZE_DEF = 8;
  localparam int RAM_ADRSIZE_DEF  = 5;
  localparam int RAMDEPTH_DEF     = 1 << RAM_ADRSIZE_DEF;
  localparam int RAM_RDLAT_DEF    = 1;
  localparam int RAM_RDLAT_MIN    = 1;
  localparam int RAM_RDLAT_MAX    = 4;

endpackage

// File: rtl/ram_rdpipe.sv
// Read-latency delay line (LAT-1 stages of data plus valid)
// followed by the DOUT/DVALID output register that holds data.
module ram_rdpipe
  import ram_pkg::*;
#(
  parameter int W   = RAM_DATASIZE_DEF,
  parameter int LAT = RAM_RDLAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic         tail_vld;
  logic [W-1:0] tail_data;

  generate
    if (LAT > 1) begin : g_dly
      logic         vld_q [LAT-1];
      logic [W-1:0] dat_q [LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT-1; i++) begin
            vld_q[i] <= 1'b0;
            dat_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= in_vld;
          dat_q[0] <= in_data;
          for (int i = 1; i < LAT-1; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign tail_vld  = vld_q[LAT-2];
      assign tail_data = dat_q[LAT-2];
    end else begin : g_thru
      assign tail_vld  = in_vld;
      assign tail_data = in_data;
    end
  endgenerate

  // DOUT only moves when a read completes; DVALID is a 1-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      out_vld <= tail_vld;
      if (tail_vld) begin
        out_data <= tail_data;
      end
    end
  end

endmodule

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with self-clearing array,
// configurable read latency and a CLR request input.
module sync_ram
  import ram_pkg::*;
#(
  parameter int RAM_DATASIZE = RAM_DATASIZE_DEF,
  parameter int RAM_ADRSIZE  = RAM_ADRSIZE_DEF,
  parameter int RAMDEPTH     = 1 << RAM_ADRSIZE,
  parameter int RAM_RDLAT    = RAM_RDLAT_DEF
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    CS_N,
  input  logic                    WE,
  input  logic [RAM_ADRSIZE-1:0]  ADR,
  input  logic [RAM_DATASIZE-1:0] DIN,
  input  logic                    CLR,
  output logic [RAM_DATASIZE-1:0] DOUT,
  output logic                    DVALID,
  output logic                    RDY
);

  localparam int LAT =
    (RAM_RDLAT < RAM_RDLAT_MIN) ? RAM_RDLAT_MIN :
    (RAM_RDLAT > RAM_RDLAT_MAX) ? RAM_RDLAT_MAX :
    RAM_RDLAT;

  localparam logic [RAM_ADRSIZE:0] DEPTH_L =
    (RAM_ADRSIZE+1)'(RAMDEPTH);

  ram_state_t               state;
  logic [RAM_ADRSIZE:0]     clr_cnt;
  logic [RAM_ADRSIZE-1:0]   clr_idx;
  logic                     rdy_q;

  logic [RAM_DATASIZE-1:0]  mem [RAMDEPTH];

  logic                     clr_we;
  logic                     acc;
  logic                     in_rng;
  logic                     wr_en;
  logic                     rd_en;
  logic [RAM_DATASIZE-1:0]  rd_data;

  assign clr_idx = clr_cnt[RAM_ADRSIZE-1:0];
  assign clr_we  = (state == ST_CLEAR) && (clr_cnt != DEPTH_L);
  assign acc     = rdy_q && !CS_N && !CLR;
  assign in_rng  = {1'b0, ADR} < DEPTH_L;
  assign wr_en   = acc && WE && in_rng;
  assign rd_en   = acc && !WE;
  assign rd_data = in_rng ? mem[ADR] : '0;

  // Counter parks at DEPTH_L for one edge before ST_READY
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      rdy_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          if (clr_cnt == DEPTH_L) begin
            state <= ST_READY;
            rdy_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (CLR) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            rdy_q   <= 1'b0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          rdy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    unique case (1'b1)
      clr_we:  mem[clr_idx] <= '0;
      wr_en:   mem[ADR]     <= DIN;
      default: ;
    endcase
  end

  ram_rdpipe #(
    .W   (RAM_DATASIZE),
    .LAT (LAT)
  ) u_rdpipe (
    .clk      (CLK),
    .rst_n    (RST_N),
    .in_vld   (rd_en),
    .in_data  (rd_data),
    .out_vld  (DVALID),
    .out_data (DOUT)
  );

  assign RDY = rdy_q;

endmodule
